// File: rtl/arm7tdmi_pkg.sv
// Shared ARM7TDMI types: coprocessor op codes, sequencer states and CP15
// maintenance register numbers.
package arm7tdmi_pkg;

  typedef enum logic [2:0] {
    CP_CDP = 3'd0,
    CP_MCR = 3'd1,
    CP_MRC = 3'd2,
    CP_LDC = 3'd3,
    CP_STC = 3'd4
  } cp_op_t;

  typedef enum logic [1:0] {
    CPS_IDLE       = 2'd0,
    CPS_ISSUE      = 2'd1,
    CPS_BUSY_WAIT  = 2'd2,
    CPS_MAINT_WAIT = 2'd3
  } cp_seq_state_t;

  localparam logic [3:0] CP15_NUM       = 4'd15;
  localparam logic [3:0] CP15_CRN_CACHE = 4'd7;
  localparam logic [3:0] CP15_CRN_TLB   = 4'd8;

  typedef struct packed {
    cp_op_t      op;
    logic [3:0]  num;
    logic [3:0]  crn;
    logic [3:0]  crm;
    logic [2:0]  op1;
    logic [2:0]  op2;
    logic [3:0]  rd;
    logic [31:0] data;
  } cp_req_t;

  // CP15 c7 (cache) and c8 (TLB) writes must wait for the memory side.
  function automatic logic is_maint(input cp_req_t r);
    return (r.op == CP_MCR) && (r.num == CP15_NUM) &&
           ((r.crn == CP15_CRN_CACHE) || (r.crn == CP15_CRN_TLB));
  endfunction

endpackage

// File: rtl/arm7tdmi_cp_busy_timer.sv
// Busy-wait watchdog: counts BUSY_WAIT cycles and flags the cycle in which
// the limit is reached. Used only when ARM7TDMI_CP_TIMEOUT_EN is defined.
module arm7tdmi_cp_busy_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         count <= '0;
    else if (clear)                     count <= '0;
    else if (inc && count != 16'hffff)  count <= count + 16'd1;
  end

  // count holds completed BUSY_WAIT cycles, so this is the limit-th one.
  assign expired = inc && (count == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/arm7tdmi_cp_sequencer.sv
// Coprocessor instruction sequencer: launch, busy-wait, CP15 maintenance hold,
// MRC writeback. Optional busy-wait timeout under ARM7TDMI_CP_TIMEOUT_EN.
module arm7tdmi_cp_sequencer
  import arm7tdmi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  cp_op_t      issue_op,
  input  logic [3:0]  issue_num,
  input  logic [3:0]  issue_crn,
  input  logic [3:0]  issue_crm,
  input  logic [2:0]  issue_op1,
  input  logic [2:0]  issue_op2,
  input  logic [3:0]  issue_rd,
  input  logic [31:0] issue_data,
  input  logic        pipe_flush,
  input  logic        irq_pending,
  output logic        cp_en,
  output cp_op_t      cp_op,
  output logic [3:0]  cp_num,
  output logic [3:0]  cp_crn,
  output logic [3:0]  cp_crm,
  output logic [2:0]  cp_op1,
  output logic [2:0]  cp_op2,
  output logic [31:0] cp_data_in,
  input  logic        cp_busy,
  input  logic        cp_absent,
  input  logic [31:0] cp_data_out,
  output logic        maint_req,
  input  logic        maint_ack,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        retire,
  output logic        undef_trap,
  output logic        abandon,
  output logic        stall
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  cp_seq_state_t state_q, state_d;
  cp_req_t       req_q;
  logic          accept, capture, timeout;
  logic          retire_d, undef_d, abandon_d, wb_d;

  assign accept = (state_q == CPS_IDLE) && issue_valid;

`ifdef ARM7TDMI_CP_TIMEOUT_EN
  logic expired;

  arm7tdmi_cp_busy_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .inc     (state_q == CPS_BUSY_WAIT),
    .expired (expired)
  );

  assign timeout = expired && cp_busy;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CPS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    retire_d  = 1'b0;
    undef_d   = 1'b0;
    abandon_d = 1'b0;
    wb_d      = 1'b0;
    case (state_q)
      CPS_IDLE: begin
        if (issue_valid) begin
          capture = 1'b1;
          // No memory path here: LDC/STC trap straight from IDLE.
          if (issue_op == CP_LDC || issue_op == CP_STC) undef_d = 1'b1;
          else                                          state_d = CPS_ISSUE;
        end
      end
      CPS_ISSUE, CPS_BUSY_WAIT: begin
        if (pipe_flush) begin
          state_d = CPS_IDLE;
        end else if (cp_absent || timeout) begin
          undef_d = 1'b1;
          state_d = CPS_IDLE;
        end else if (cp_busy) begin
          if (state_q == CPS_BUSY_WAIT && irq_pending) begin
            abandon_d = 1'b1;
            state_d   = CPS_IDLE;
          end else begin
            state_d = CPS_BUSY_WAIT;
          end
        end else if (req_q.op == CP_MRC) begin
          wb_d     = 1'b1;
          retire_d = 1'b1;
          state_d  = CPS_IDLE;
        end else if (is_maint(req_q)) begin
          state_d = CPS_MAINT_WAIT;
        end else begin
          retire_d = 1'b1;
          state_d  = CPS_IDLE;
        end
      end
      CPS_MAINT_WAIT: begin
        // Flush and IRQ are deliberately ignored: the op is already in flight.
        if (maint_ack) begin
          retire_d = 1'b1;
          state_d  = CPS_IDLE;
        end
      end
      default: state_d = CPS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if (capture) begin
      req_q <= '{op: issue_op, num: issue_num, crn: issue_crn, crm: issue_crm,
                 op1: issue_op1, op2: issue_op2, rd: issue_rd, data: issue_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire     <= 1'b0;
      undef_trap <= 1'b0;
      abandon    <= 1'b0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      retire     <= retire_d;
      undef_trap <= undef_d;
      abandon    <= abandon_d;
      wb_valid   <= wb_d;
      if (wb_d) begin
        wb_rd   <= req_q.rd;
        wb_data <= cp_data_out;
      end
    end
  end

  assign issue_ready = (state_q == CPS_IDLE);
  assign stall       = (state_q != CPS_IDLE);
  assign cp_en       = (state_q == CPS_ISSUE) || (state_q == CPS_BUSY_WAIT);
  assign maint_req   = (state_q == CPS_MAINT_WAIT);

  assign cp_op      = req_q.op;
  assign cp_num     = req_q.num;
  assign cp_crn     = req_q.crn;
  assign cp_crm     = req_q.crm;
  assign cp_op1     = req_q.op1;
  assign cp_op2     = req_q.op2;
  assign cp_data_in = req_q.data;

endmodule

// File: tb/tb_arm7tdmi_cp_sequencer.sv
// Scoreboard bench for arm7tdmi_cp_sequencer (default build, timeout disabled).
module tb_arm7tdmi_cp_sequencer;
  import arm7tdmi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0, issue_ready;
  cp_op_t      issue_op = CP_CDP;
  logic [3:0]  issue_num = '0, issue_crn = '0, issue_crm = '0, issue_rd = '0;
  logic [2:0]  issue_op1 = '0, issue_op2 = '0;
  logic [31:0] issue_data = '0;
  logic        pipe_flush = 1'b0, irq_pending = 1'b0;
  logic        cp_en;
  cp_op_t      cp_op;
  logic [3:0]  cp_num, cp_crn, cp_crm;
  logic [2:0]  cp_op1, cp_op2;
  logic [31:0] cp_data_in;
  logic        cp_busy = 1'b0, cp_absent = 1'b0;
  logic [31:0] cp_data_out = '0;
  logic        maint_req, maint_ack = 1'b0;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        retire, undef_trap, abandon, stall;

  always #5 clk = ~clk;

  arm7tdmi_cp_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_num(issue_num), .issue_crn(issue_crn), .issue_crm(issue_crm),
    .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_rd(issue_rd),
    .issue_data(issue_data), .pipe_flush(pipe_flush), .irq_pending(irq_pending),
    .cp_en(cp_en), .cp_op(cp_op), .cp_num(cp_num), .cp_crn(cp_crn), .cp_crm(cp_crm),
    .cp_op1(cp_op1), .cp_op2(cp_op2), .cp_data_in(cp_data_in),
    .cp_busy(cp_busy), .cp_absent(cp_absent), .cp_data_out(cp_data_out),
    .maint_req(maint_req), .maint_ack(maint_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .retire(retire), .undef_trap(undef_trap), .abandon(abandon), .stall(stall)
  );

  localparam logic [2:0] K_RET = 3'b001, K_UND = 3'b010, K_ABN = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    logic        wb;
    logic [3:0]  rd;
    logic [31:0] data;
    int          when;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   cyc = 0;
  int   chk = 0, pass = 0;

  // cyc counts edges; the cycle after edge e is cycle e+1.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (retire || undef_trap || abandon || wb_valid) begin
      chk++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_pulse: abn/und/ret/wb=%b%b%b%b in cycle %0d, required none",
                 abandon, undef_trap, retire, wb_valid, cyc + 1);
      end else begin
        pass++;
        me = q.pop_front();
        chk++;
        if ({abandon, undef_trap, retire} !== me.kind)
          $display("FAIL pulse_kind: got %b required %b", {abandon, undef_trap, retire}, me.kind);
        else pass++;
        chk++;
        if (cyc + 1 != me.when)
          $display("FAIL pulse_cycle: got %0d required %0d", cyc + 1, me.when);
        else pass++;
        chk++;
        if (wb_valid !== me.wb)
          $display("FAIL wb_valid: got %b required %b", wb_valid, me.wb);
        else pass++;
        if (me.wb) begin
          chk++;
          if (wb_rd !== me.rd || wb_data !== me.data)
            $display("FAIL wb_result: got rd=%0d data=%h required rd=%0d data=%h",
                     wb_rd, wb_data, me.rd, me.data);
          else pass++;
        end
      end
    end
  end

  task automatic wait_now(input int t);
    do @(negedge clk); while (cyc + 1 < t);
  endtask

  task automatic issue(input cp_op_t op, input logic [3:0] num, crn, crm,
                       input logic [2:0] op1, op2, input logic [3:0] rd,
                       input logic [31:0] data, output int n);
    int w = 0;
    @(negedge clk);
    while (!issue_ready && w < 50) begin @(negedge clk); w++; end
    chk++;
    if (!issue_ready) $display("FAIL issue_ready_wait: got 0 required 1 within 50 cycles");
    else pass++;
    issue_op = op; issue_num = num; issue_crn = crn; issue_crm = crm;
    issue_op1 = op1; issue_op2 = op2; issue_rd = rd; issue_data = data;
    issue_valid = 1'b1;
    n = cyc + 1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (q.size() != 0 && w < 30) begin @(negedge clk); w++; end
    chk++;
    if (q.size() != 0) $display("FAIL %s_missing_pulse: got %0d outstanding required 0", name, q.size());
    else pass++;
    q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk++;
    if ({issue_ready, stall, cp_en, maint_req} !== 4'b1000)
      $display("FAIL reset_state: got rdy/stall/en/mreq=%b required 1000", {issue_ready, stall, cp_en, maint_req});
    else pass++;
    chk++;
    if ({wb_valid, retire, undef_trap, abandon} !== 4'b0000 || wb_data !== 32'h0 || wb_rd !== 4'h0)
      $display("FAIL reset_pulses: got %b data=%h required 0000 data=0", {wb_valid, retire, undef_trap, abandon}, wb_data);
    else pass++;
    chk++;
    if (cp_num !== 4'h0 || cp_data_in !== 32'h0 || cp_op !== CP_CDP)
      $display("FAIL reset_hold: got num=%0d data=%h required 0", cp_num, cp_data_in);
    else pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mrc();
    int n;
    cp_data_out = 32'h41007000;
    issue(CP_MRC, 4'd15, 4'd0, 4'd0, 3'd0, 3'd0, 4'd3, 32'h0, n);
    q.push_back('{K_RET, 1'b1, 4'd3, 32'h41007000, n + 2});
    wait_now(n + 1);
    chk++;
    if (!(cp_en === 1'b1 && stall === 1'b1 && cp_num === 4'd15 && cp_op === CP_MRC))
      $display("FAIL mrc_launch: got en=%b stall=%b num=%0d required 1 1 15", cp_en, stall, cp_num);
    else pass++;
    wait_now(n + 2);
    chk++;
    if (issue_ready !== 1'b1) $display("FAIL mrc_ready_again: got %b required 1", issue_ready);
    else pass++;
    drain("mrc");
  endtask

  task automatic test_absent();
    int n;
    cp_absent = 1'b1;
    issue(CP_MCR, 4'd14, 4'd1, 4'd2, 3'd0, 3'd0, 4'd0, 32'h1234, n);
    q.push_back('{K_UND, 1'b0, 4'd0, 32'h0, n + 2});
    wait_now(n + 1);
    chk++;
    if (cp_en !== 1'b1 || cp_num !== 4'd14) $display("FAIL absent_launch: got en=%b num=%0d required 1 14", cp_en, cp_num);
    else pass++;
    wait_now(n + 2);
    cp_absent = 1'b0;
    issue(CP_CDP, 4'd14, 4'd1, 4'd1, 3'd2, 3'd1, 4'd0, 32'h0, n);
    q.push_back('{K_RET, 1'b0, 4'd0, 32'h0, n + 2});
    drain("absent");
  endtask

  task automatic test_maint();
    int n, mcnt = 0;
    issue(CP_MCR, 4'd15, 4'd7, 4'd5, 3'd0, 3'd0, 4'd0, 32'hdeadbeef, n);
    q.push_back('{K_RET, 1'b0, 4'd0, 32'h0, n + 7});
    maint_ack = 1'b1;  // early ack while still in ISSUE must be ignored
    wait_now(n + 1);
    chk++;
    if (cp_en !== 1'b1 || cp_data_in !== 32'hdeadbeef || cp_crn !== 4'd7 || cp_crm !== 4'd5)
      $display("FAIL maint_launch: got en=%b data=%h crn=%0d crm=%0d required 1 deadbeef 7 5", cp_en, cp_data_in, cp_crn, cp_crm);
    else pass++;
    for (int t = n + 2; t <= n + 7; t++) begin
      wait_now(t);
      if (maint_req) mcnt++;
      if (t == n + 2) begin
        maint_ack = 1'b0;
        chk++;
        if (cp_en !== 1'b0 || stall !== 1'b1) $display("FAIL maint_cp_en: got en=%b stall=%b required 0 1", cp_en, stall);
        else pass++;
      end
      if (t == n + 3) pipe_flush = 1'b1;
      if (t == n + 4) pipe_flush = 1'b0;
      if (t == n + 6) maint_ack = 1'b1;
      if (t == n + 7) maint_ack = 1'b0;
    end
    chk++;
    if (mcnt != 5) $display("FAIL maint_req_cycles: got %0d required 5", mcnt);
    else pass++;
    chk++;
    if (issue_ready !== 1'b1) $display("FAIL maint_ready_after: got %b required 1", issue_ready);
    else pass++;
    drain("maint");
  endtask

  task automatic test_busy();
    int n, ecnt = 0;
    cp_busy = 1'b1;
    issue(CP_CDP, 4'd10, 4'd3, 4'd4, 3'd1, 3'd2, 4'd0, 32'h0, n);
    q.push_back('{K_RET, 1'b0, 4'd0, 32'h0, n + 5});
    for (int t = n + 1; t <= n + 6; t++) begin
      wait_now(t);
      if (cp_en) ecnt++;
      if (t == n + 4) cp_busy = 1'b0;
    end
    chk++;
    if (ecnt != 4) $display("FAIL busy_cp_en_cycles: got %0d required 4", ecnt);
    else pass++;
    drain("busy");
    cp_busy = 1'b1;
    issue(CP_CDP, 4'd10, 4'd3, 4'd4, 3'd1, 3'd2, 4'd0, 32'h0, n);
    q.push_back('{K_ABN, 1'b0, 4'd0, 32'h0, n + 3});
    wait_now(n + 2);
    irq_pending = 1'b1;
    wait_now(n + 3);
    chk++;
    if (cp_en !== 1'b0 || issue_ready !== 1'b1) $display("FAIL abandon_cp_en: got en=%b rdy=%b required 0 1", cp_en, issue_ready);
    else pass++;
    irq_pending = 1'b0;
    cp_busy = 1'b0;
    drain("abandon");
  endtask

  task automatic test_flush();
    int n;
    cp_busy = 1'b1;
    issue(CP_MCR, 4'd5, 4'd1, 4'd0, 3'd0, 3'd0, 4'd0, 32'h55, n);
    wait_now(n + 2);
    pipe_flush = 1'b1;
    wait_now(n + 3);
    pipe_flush = 1'b0;
    cp_busy = 1'b0;
    chk++;
    if (issue_ready !== 1'b1 || cp_en !== 1'b0) $display("FAIL flush_idle: got rdy=%b en=%b required 1 0", issue_ready, cp_en);
    else pass++;
    repeat (3) @(negedge clk);
    drain("flush");
  endtask

  task automatic test_back_to_back();
    int n;
    issue(CP_LDC, 4'd6, 4'd0, 4'd0, 3'd0, 3'd0, 4'd0, 32'h0, n);
    q.push_back('{K_UND, 1'b0, 4'd0, 32'h0, n + 1});
    issue(CP_STC, 4'd6, 4'd0, 4'd0, 3'd0, 3'd0, 4'd0, 32'h0, n);
    q.push_back('{K_UND, 1'b0, 4'd0, 32'h0, n + 1});
    cp_data_out = 32'h12345678;
    issue(CP_MRC, 4'd15, 4'd1, 4'd0, 3'd0, 3'd0, 4'd7, 32'h0, n);
    q.push_back('{K_RET, 1'b1, 4'd7, 32'h12345678, n + 2});
    issue(CP_MCR, 4'd15, 4'd1, 4'd0, 3'd0, 3'd0, 4'd0, 32'h0000_1078, n);
    q.push_back('{K_RET, 1'b0, 4'd0, 32'h0, n + 2});
    drain("back_to_back");
  endtask

  task automatic test_no_timeout();
    int n, scnt = 0;
    cp_busy = 1'b1;
    issue(CP_CDP, 4'd3, 4'd0, 4'd0, 3'd0, 3'd0, 4'd0, 32'h0, n);
    for (int t = n + 1; t <= n + 1000; t++) begin
      wait_now(t);
      if (stall && cp_en) scnt++;
    end
    chk++;
    if (scnt != 1000) $display("FAIL no_timeout_stall: got %0d required 1000", scnt);
    else pass++;
    pipe_flush = 1'b1;
    @(negedge clk);
    pipe_flush = 1'b0;
    cp_busy = 1'b0;
    @(negedge clk);
    chk++;
    if (stall !== 1'b0) $display("FAIL no_timeout_flush: got stall=%b required 0", stall);
    else pass++;
    drain("no_timeout");
  endtask

  task automatic test_reset_mid();
    int n;
    cp_busy = 1'b1;
    issue(CP_CDP, 4'd9, 4'd2, 4'd0, 3'd0, 3'd0, 4'd0, 32'hffff, n);
    wait_now(n + 3);
    chk++;
    if (cp_en !== 1'b1) $display("FAIL reset_mid_pre: got en=%b required 1", cp_en);
    else pass++;
    #2 rst_n = 1'b0;
    #1;
    chk++;
    if ({issue_ready, stall, cp_en, maint_req, retire, undef_trap, abandon, wb_valid} !== 8'b1000_0000 ||
        cp_num !== 4'd0 || cp_data_in !== 32'h0)
      $display("FAIL reset_mid_outputs: got %b num=%0d required 10000000 num=0",
               {issue_ready, stall, cp_en, maint_req, retire, undef_trap, abandon, wb_valid}, cp_num);
    else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    cp_busy = 1'b0;
    repeat (3) @(negedge clk);
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_mrc();
    test_absent();
    test_maint();
    test_busy();
    test_flush();
    test_back_to_back();
    test_no_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
